// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Latency: none (package only).
// Backpressure: not applicable.
package seq_detect_pkg;

  // Overlap mode encodings for cfg_overlap / overlap_r
  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Legal pattern-length range
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 32;

  // True when a pattern length is inside the supported range
  function automatic bit pat_len_ok(input int len);
    return (len >= PAT_LEN_MIN) && (len <= PAT_LEN_MAX);
  endfunction

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: q updates on the edge where inc/clr are sampled.
// Backpressure: none; clr wins over inc, count holds at all-ones.
module sat_counter
  import seq_detect_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // Reset/clear to zero, otherwise count up and stick at MAX
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), 32'(MAX)));
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with overlap control and match counter.
// Latency: match is registered, high the cycle after the completing bit.
// Backpressure: none; in_valid qualifies bits, idle cycles leave history untouched.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_LEN-1:0] RST_PAT     = 4'b1011,
  parameter logic               RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               primed
);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $error("seq_detect_param: PAT_LEN out of range");
  end

  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_sh;
  logic [PAT_LEN-1:0] pattern_r;
  logic               overlap_r;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_inc;
  logic               hit;

  // Candidate history/fill for an accepted bit and the match compare on it
  always_comb begin
    hist_sh  = {hist[PAT_LEN-2:0], in};
    fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
    hit      = 1'b0;
    if (in_valid && !cfg_load && (fill_inc == FULL) && (hist_sh == pattern_r)) begin
      hit = 1'b1;
    end
  end

  // History, fill, configuration and match pulse; rst > cfg_load > accepted bit
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pattern_r <= RST_PAT;
      overlap_r <= RST_OVERLAP;
      match     <= 1'b0;
    end else if (cfg_load) begin
      hist      <= '0;
      fill      <= '0;
      pattern_r <= cfg_pattern;
      overlap_r <= cfg_overlap;
      match     <= 1'b0;
    end else if (in_valid) begin
      hist  <= hist_sh;
      // Non-overlapping mode restarts the window so the next match needs fresh bits
      fill  <= (hit && (overlap_r == NON_OVERLAP)) ? '0 : fill_inc;
      match <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  assign primed = (fill == FULL);

  sat_counter #(.W(CNT_W)) u_match_count (
    .clk (clk),
    .rst (rst),
    .clr (clr_count),
    .inc (hit),
    .q   (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a 4-bit/8-bit-count instance and a 3-bit/2-bit-count instance.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       in_valid;
  logic       cfg_load;
  logic [3:0] cfg_pattern4;
  logic [2:0] cfg_pattern3;
  logic       cfg_overlap;
  logic       clr_count;

  logic       match_a;
  logic [7:0] count_a;
  logic       primed_a;
  logic       match_b;
  logic [1:0] count_b;
  logic       primed_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_LEN(4), .CNT_W(8), .RST_PAT(4'b1011), .RST_OVERLAP(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern4), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match_a), .match_count(count_a), .primed(primed_a)
  );

  seq_detect_param #(
    .PAT_LEN(3), .CNT_W(2), .RST_PAT(3'b101), .RST_OVERLAP(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern3), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match_b), .match_count(count_b), .primed(primed_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given bit; one-shot controls drop afterwards
  task automatic step(input logic b, input logic v);
    in       = b;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_load  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic load(input logic [3:0] p4, input logic [2:0] p3, input logic ov);
    cfg_pattern4 = p4;
    cfg_pattern3 = p3;
    cfg_overlap  = ov;
    cfg_load     = 1'b1;
    clr_count    = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern4 = 4'b0000; cfg_pattern3 = 3'b000; cfg_overlap = 1'b1; clr_count = 1'b0;

    // Reset defaults
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_match", match_a, 1'b0);
    check("rst_count", count_a, 8'd0);
    check("rst_primed", primed_a, 1'b0);

    // Default pattern 1011 on instance A
    step(1, 1); check("def_b1_match", match_a, 1'b0);
    step(0, 1); check("def_b2_match", match_a, 1'b0);
    step(1, 1); check("def_b3_match", match_a, 1'b0);
                check("def_b3_primed", primed_a, 1'b0);
    step(1, 1); check("def_b4_match", match_a, 1'b1);
                check("def_b4_count", count_a, 8'd1);
                check("def_b4_primed", primed_a, 1'b1);
    step(0, 0); check("def_idle_match", match_a, 1'b0);
                check("def_idle_count", count_a, 8'd1);

    // Overlapping 101 on instance B
    load(4'b0000, 3'b101, 1'b1);
    check("ov_load_count", count_b, 2'd0);
    step(1, 1); check("ov_b1", match_b, 1'b0);
    step(0, 1); check("ov_b2", match_b, 1'b0);
    step(1, 1); check("ov_b3", match_b, 1'b1);
    step(0, 1); check("ov_b4", match_b, 1'b0);
    step(1, 1); check("ov_b5", match_b, 1'b1);
                check("ov_count", count_b, 2'd2);

    // Non-overlapping 101 on instance B
    load(4'b0000, 3'b101, 1'b0);
    step(1, 1); check("nov_b1", match_b, 1'b0);
    step(0, 1); check("nov_b2", match_b, 1'b0);
    step(1, 1); check("nov_b3", match_b, 1'b1);
                check("nov_b3_primed", primed_b, 1'b0);
    step(0, 1); check("nov_b4", match_b, 1'b0);
    step(1, 1); check("nov_b5", match_b, 1'b0);
                check("nov_count", count_b, 2'd1);

    // Gapped input on instance A
    load(4'b1011, 3'b000, 1'b1);
    step(1, 1); step(0, 0);
    step(0, 1); step(0, 0); check("gap_idle_match", match_a, 1'b0);
    step(1, 1); step(1, 0);
    step(1, 1); check("gap_match", match_a, 1'b1);
                check("gap_count", count_a, 8'd1);
    step(0, 0); check("gap_after", match_a, 1'b0);

    // cfg_load on the completing bit discards it
    step(1, 1); step(0, 1); step(1, 1);
    cfg_pattern4 = 4'b1011; cfg_overlap = 1'b1; cfg_load = 1'b1;
    step(1, 1); check("cfgc_match", match_a, 1'b0);
                check("cfgc_primed", primed_a, 1'b0);
                check("cfgc_count", count_a, 8'd1);
    step(1, 1); check("cfgc_next", match_a, 1'b0);

    // Saturation on instance B (2-bit counter, 5 matches)
    load(4'b0000, 3'b101, 1'b1);
    step(1, 1); step(0, 1); step(1, 1); step(0, 1); step(1, 1);
    step(0, 1); step(1, 1); check("sat_3rd", count_b, 2'd3);
    step(0, 1); step(1, 1); check("sat_4th_match", match_b, 1'b1);
                check("sat_4th_count", count_b, 2'd3);
    step(0, 1); step(1, 1); check("sat_5th_count", count_b, 2'd3);

    // clr_count on the same edge as a match
    step(0, 1);
    clr_count = 1'b1;
    step(1, 1); check("clr_match", match_b, 1'b1);
                check("clr_count", count_b, 2'd0);

    // Reset mid-operation restores the reset pattern on A
    load(4'b0110, 3'b000, 1'b1);
    step(0, 1); step(1, 1); step(1, 1);
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    check("mid_rst_primed", primed_a, 1'b0);
    check("mid_rst_count", count_a, 8'd0);
    step(0, 1); step(1, 1); step(1, 1);
    step(0, 1); check("mid_0110", match_a, 1'b0);
                check("mid_0110_primed", primed_a, 1'b1);
    step(1, 1); check("mid_1101", match_a, 1'b0);
    step(0, 1); check("mid_1010", match_a, 1'b0);
    step(1, 1); check("mid_0101", match_a, 1'b0);
    step(1, 1); check("mid_1011", match_a, 1'b1);
                check("mid_count", count_a, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the next generation of the fixed 3-bit "101" Moore detector. It adds a runtime-loadable pattern of PAT_LEN bits, selectable overlapping or non-overlapping matching, and a qualified input stream. It produces a one-cycle match pulse and a saturating match counter. It sits between a bit-serial source (deserialiser or LFSR test stream) and control logic that needs framing or sync-word detection.

## Interface
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of match counter.
- RST_PAT, 4'b1011, pattern value after reset; PAT_LEN bits wide, MSB is the first bit received.
- RST_OVERLAP, 1, overlap mode after reset (1 = overlapping, 0 = non-overlapping).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset.
- in  in  1  serial data bit.
- in_valid  in  1  `in` is sampled only on edges where this is 1.
- cfg_load  in  1  load cfg_pattern / cfg_overlap and flush history.
- cfg_pattern  in  PAT_LEN  new pattern, MSB first-received.
- cfg_overlap  in  1  new overlap mode.
- clr_count  in  1  zero match_count.
- match  out  1  one-cycle pulse, asserted the cycle after the bit that completes the pattern.
- match_count  out  CNT_W  number of matches, saturating at all-ones.
- primed  out  1  history holds PAT_LEN valid bits (fill == PAT_LEN).

## Operation
- State:
  - hist[PAT_LEN-1:0]: shift register, newest bit in the LSB.
  - fill: 0..PAT_LEN, saturating.
  - pattern_r and overlap_r.
  - match_count.
- Accepted bit (in_valid=1, cfg_load=0, rst=0):
  - hist <= {hist[PAT_LEN-2:0], in}.
  - fill_n = min(fill+1, PAT_LEN).
- Match condition: fill_n == PAT_LEN and the shifted hist == pattern_r. Evaluated only on accepted bits.
- On match:
  - Overlapping mode: fill stays PAT_LEN, so suffix/prefix overlaps detect (pattern 101 on 10101 gives 2 matches).
  - Non-overlapping mode: fill <= 0, and the next match needs PAT_LEN fresh bits.
- No accepted bit: hist, fill, and match_count hold; match <= 0.
- cfg_load=1:
  - pattern_r <= cfg_pattern and overlap_r <= cfg_overlap.
  - hist <= 0 and fill <= 0.
  - A simultaneous in_valid bit is discarded and no match is generated.
  - match_count is unaffected.
- Counter increments on match, saturates at 2^CNT_W-1, and holds there.
- clr_count and a match in the same cycle: clear wins, match_count = 0. The match pulse is still emitted.
- Priority: rst > cfg_load > accepted bit. clr_count is independent of cfg_load.

## Timing
- Reset values:
  - match=0, match_count=0, primed=0.
  - hist=0, fill=0.
  - pattern_r=RST_PAT, overlap_r=RST_OVERLAP.
- Latency: match is registered. Completing bit sampled at edge N gives match high during cycle N to N+1, low afterwards unless another match occurs.
- match_count reflects a match from the same edge as match rises.
- Back-to-back matches on consecutive accepted bits (overlap, pattern 1111 on a stream of 1s) give match held high for consecutive cycles, one count per cycle.
- primed updates on the same edge as fill.
- rst mid-stream: all state returns to reset values on that edge, including a pattern previously loaded with cfg_load. A bit presented during rst is lost.
- Gaps in in_valid are transparent: the pattern may span any number of idle cycles.

## Structure
- Package seq_detect_pkg holds:
  - OVERLAP / NON_OVERLAP mode constants.
  - A function for saturating increment.
  - The PAT_LEN range check constant.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q), instantiated once for match_count.
- Everything else lives in one module: a single registered always block plus the combinational match compare.

## Test plan
- Reset defaults: hold rst 3 cycles, then check match=0, count=0, primed=0. Send 1,0,1,1 → match pulse after the 4th bit, count=1.
- Overlap: cfg_load pattern 3'b101 (PAT_LEN=3) with overlap=1. Stream 1,0,1,0,1 → matches after bits 3 and 5, count=2.
- Non-overlap: same pattern with overlap=0, same stream → single match after bit 3, count=1, primed=0 after the match.
- Gapped input and simultaneous events:
  - Pattern 1011 with in_valid toggled every other cycle → still 1 match.
  - cfg_load asserted with in_valid on the completing bit → no match, fill=0.
- Saturation and clear:
  - CNT_W=2 with 5 matches → count holds at 3.
  - clr_count on the same edge as a match → count=0 and match=1.
- Reset mid-operation: after cfg_load of 0110, assert rst after 3 bits → pattern back to RST_PAT. Stream 0110 gives no match; stream 1011 gives a match.
